// File: rtl/irig_time_keeper.sv
// irig_time_keeper
// Keeps IRIG-B time of day downstream of the BCD decoder. Frames from the
// decoder load the time; PPS edges step it; without PPS the block free-runs
// in holdover on the local clock. A synchronised external event snapshots the
// running {time, subsec} until the consumer acknowledges it.

module irig_time_keeper #(
  parameter int CLK_FREQ = 125_000_000,
  parameter int PPS_TOL  = 1000,
  parameter int SUBSEC_W = 27
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          sec,
  input  logic [5:0]          min,
  input  logic [4:0]          hr,
  input  logic [8:0]          day,
  input  logic                bcd_valid,
  input  logic                pps,
  input  logic                leap_year,
  input  logic                event_in,
  input  logic                ev_ack,
  output logic [25:0]         time_o,
  output logic [SUBSEC_W-1:0] subsec_o,
  output logic                locked,
  output logic                holdover,
  output logic [25:0]         ev_time,
  output logic [SUBSEC_W-1:0] ev_subsec,
  output logic                ev_valid,
  output logic                ev_overrun,
  output logic [15:0]         pps_err_cnt
);

  typedef enum logic [1:0] {
    ST_UNSYNC   = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_HOLDOVER = 2'd2
  } state_t;

  // Earliest subsecond at which a PPS edge counts as a genuine second boundary.
  localparam logic [SUBSEC_W-1:0] ACCEPT_MIN = SUBSEC_W'(CLK_FREQ - PPS_TOL);
  // Last subsecond the locked state waits for PPS before declaring it lost.
  localparam logic [SUBSEC_W-1:0] LOCK_LAST  = SUBSEC_W'(CLK_FREQ + PPS_TOL - 1);
  // Local-oscillator second length used while in holdover.
  localparam logic [SUBSEC_W-1:0] HOLD_LAST  = SUBSEC_W'(CLK_FREQ - 1);
  localparam logic [SUBSEC_W-1:0] TOL        = SUBSEC_W'(PPS_TOL);
  localparam logic [SUBSEC_W-1:0] ONE        = SUBSEC_W'(1);

  // One-second step of a packed {day,hr,min,sec} value with year rollover.
  function automatic logic [25:0] advance_time(input logic [25:0] t, input logic leap);
    logic [8:0] d;
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    {d, h, m, s} = t;
    if (s >= 6'd59) begin
      s = 6'd0;
      if (m >= 6'd59) begin
        m = 6'd0;
        if (h >= 5'd23) begin
          h = 5'd0;
          if (d >= (leap ? 9'd366 : 9'd365)) begin
            d = 9'd1;
          end else begin
            d = d + 9'd1;
          end
        end else begin
          h = h + 5'd1;
        end
      end else begin
        m = m + 6'd1;
      end
    end else begin
      s = s + 6'd1;
    end
    return {d, h, m, s};
  endfunction

  state_t              state_q, state_d;
  logic                pps_q, pps_d;
  logic                bcd_valid_q, bcd_valid_d;
  logic [2:0]          ev_sync_q, ev_sync_d;
  logic [25:0]         time_q, time_d;
  logic [SUBSEC_W-1:0] subsec_q, subsec_d;
  logic                first_pps_q, first_pps_d;
  logic [15:0]         err_q, err_d;
  logic [25:0]         ev_time_q, ev_time_d;
  logic [SUBSEC_W-1:0] ev_subsec_q, ev_subsec_d;
  logic                ev_valid_q, ev_valid_d;
  logic                ev_overrun_q, ev_overrun_d;

  logic                pps_rise_s;
  logic                load_rise_s;
  logic                ev_rise_s;
  logic                err_inc_s;

  // Edge detectors and the event synchroniser shift chain.
  always_comb begin
    pps_d       = pps;
    bcd_valid_d = bcd_valid;
    ev_sync_d   = {ev_sync_q[1:0], event_in};
    pps_rise_s  = pps & ~pps_q;
    load_rise_s = bcd_valid & ~bcd_valid_q;
    ev_rise_s   = ev_sync_q[1] & ~ev_sync_q[2];
  end

  // Sync state machine: loads, PPS acceptance, holdover free-run, error count.
  always_comb begin
    state_d     = state_q;
    time_d      = time_q;
    subsec_d    = subsec_q;
    first_pps_d = first_pps_q;
    err_inc_s   = 1'b0;
    if (load_rise_s) begin
      // A new frame always wins, even over a simultaneous PPS edge.
      state_d     = ST_LOCKED;
      time_d      = {day, hr, min, sec};
      subsec_d    = '0;
      first_pps_d = 1'b1;
    end else begin
      case (state_q)
        ST_UNSYNC: begin
          time_d   = '0;
          subsec_d = '0;
        end
        ST_LOCKED: begin
          if (pps_rise_s && (first_pps_q || (subsec_q >= ACCEPT_MIN))) begin
            time_d      = advance_time(time_q, leap_year);
            subsec_d    = '0;
            first_pps_d = 1'b0;
          end else if (subsec_q >= LOCK_LAST) begin
            // PPS missing: step the second late and carry the overshoot.
            time_d      = advance_time(time_q, leap_year);
            subsec_d    = TOL;
            first_pps_d = 1'b0;
            state_d     = ST_HOLDOVER;
          end else begin
            err_inc_s = pps_rise_s;
            subsec_d  = subsec_q + ONE;
          end
        end
        ST_HOLDOVER: begin
          if (pps_rise_s && (subsec_q >= ACCEPT_MIN)) begin
            time_d   = advance_time(time_q, leap_year);
            subsec_d = '0;
            state_d  = ST_LOCKED;
          end else if (pps_rise_s && (subsec_q < TOL)) begin
            // Local second already stepped just before this PPS: re-align only.
            subsec_d = '0;
            state_d  = ST_LOCKED;
          end else if (subsec_q >= HOLD_LAST) begin
            time_d   = advance_time(time_q, leap_year);
            subsec_d = '0;
          end else begin
            err_inc_s = pps_rise_s;
            subsec_d  = subsec_q + ONE;
          end
        end
        default: begin
          state_d  = ST_UNSYNC;
          time_d   = '0;
          subsec_d = '0;
        end
      endcase
    end
    if (err_inc_s && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end else begin
      err_d = err_q;
    end
  end

  // Event capture with single-entry buffer and sticky overrun flag.
  always_comb begin
    ev_time_d    = ev_time_q;
    ev_subsec_d  = ev_subsec_q;
    ev_valid_d   = ev_valid_q;
    ev_overrun_d = ev_overrun_q;
    if (ev_rise_s && (!ev_valid_q || ev_ack)) begin
      ev_time_d    = time_q;
      ev_subsec_d  = subsec_q;
      ev_valid_d   = 1'b1;
      ev_overrun_d = 1'b0;
    end else if (ev_rise_s) begin
      ev_overrun_d = 1'b1;
    end else if (ev_ack) begin
      ev_valid_d   = 1'b0;
      ev_overrun_d = 1'b0;
    end else begin
      ev_valid_d   = ev_valid_q;
    end
  end

  // State registers; reset returns everything, including a pending event, to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_UNSYNC;
      pps_q        <= 1'b0;
      bcd_valid_q  <= 1'b0;
      ev_sync_q    <= 3'b000;
      time_q       <= 26'd0;
      subsec_q     <= '0;
      first_pps_q  <= 1'b0;
      err_q        <= 16'd0;
      ev_time_q    <= 26'd0;
      ev_subsec_q  <= '0;
      ev_valid_q   <= 1'b0;
      ev_overrun_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pps_q        <= pps_d;
      bcd_valid_q  <= bcd_valid_d;
      ev_sync_q    <= ev_sync_d;
      time_q       <= time_d;
      subsec_q     <= subsec_d;
      first_pps_q  <= first_pps_d;
      err_q        <= err_d;
      ev_time_q    <= ev_time_d;
      ev_subsec_q  <= ev_subsec_d;
      ev_valid_q   <= ev_valid_d;
      ev_overrun_q <= ev_overrun_d;
    end
  end

  assign time_o      = time_q;
  assign subsec_o    = subsec_q;
  assign locked      = (state_q == ST_LOCKED);
  assign holdover    = (state_q == ST_HOLDOVER);
  assign ev_time     = ev_time_q;
  assign ev_subsec   = ev_subsec_q;
  assign ev_valid    = ev_valid_q;
  assign ev_overrun  = ev_overrun_q;
  assign pps_err_cnt = err_q;

endmodule
